// File: rtl/div_iter_core_pkg.sv
// Shared types and widths for the iterative unsigned divider core.
// Imported by the handshake interface and the divider itself.
package div_iter_core_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } type_div_state_e;

endpackage

// File: rtl/div_iter_core_if.sv
// Start/operand request and done/result response bundle between the divide
// stage (master) and the iterative divider core (slave).
interface div_iter_core_if;
    import div_iter_core_pkg::*;

    logic            start_i;
    logic [XLEN-1:0] opr1_i;
    logic [XLEN-1:0] opr2_i;
    logic            done_o;
    logic            busy_o;
    logic [XLEN-1:0] quo_o;
    logic [XLEN-1:0] rem_o;

    modport master (
        output start_i,
        output opr1_i,
        output opr2_i,
        input  done_o,
        input  busy_o,
        input  quo_o,
        input  rem_o
    );

    modport slave (
        input  start_i,
        input  opr1_i,
        input  opr2_i,
        output done_o,
        output busy_o,
        output quo_o,
        output rem_o
    );

endinterface

// File: rtl/div_iter_core.sv
// Iterative unsigned radix-2 restoring divider: one quotient bit per cycle,
// single-cycle fast path for a zero divisor, registered one-cycle done pulse.
module div_iter_core
    import div_iter_core_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    div_iter_core_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    type_div_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN:0]    rem_acc_q, rem_acc_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [XLEN-1:0]  quo_out_q, quo_out_d;
    logic [XLEN-1:0]  rem_out_q, rem_out_d;

    logic [XLEN:0]    sh_s;
    logic [XLEN:0]    diff_s;

    // Next-state, restoring shift/subtract step and result capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        rem_acc_d = rem_acc_q;
        done_d    = 1'b0;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;

        // The partial remainder stays below the divisor, so dropping the top
        // accumulator bit in the shift loses nothing.
        sh_s   = (rem_acc_q << 1'b1) | {{XLEN{1'b0}}, quo_q[XLEN-1]};
        diff_s = sh_s - {1'b0, divisor_q};

        case (state_q)
            DIV_IDLE: begin
                if (bus.start_i) begin
                    if (bus.opr2_i != {XLEN{1'b0}}) begin
                        divisor_d = bus.opr2_i;
                        quo_d     = bus.opr1_i;
                        rem_acc_d = {(XLEN+1){1'b0}};
                        cnt_d     = CNT_LAST;
                        state_d   = DIV_CALC;
                    end else begin
                        quo_d     = {XLEN{1'b1}};
                        rem_acc_d = {1'b0, bus.opr1_i};
                        state_d   = DIV_DONE;
                    end
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_CALC: begin
                if (diff_s[XLEN] == 1'b0) begin
                    rem_acc_d = diff_s;
                    quo_d     = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_acc_d = sh_s;
                    quo_d     = {quo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == CNT_ZERO) begin
                    state_d = DIV_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DIV_DONE: begin
                done_d    = 1'b1;
                quo_out_d = quo_q;
                rem_out_d = rem_acc_q[XLEN-1:0];
                state_d   = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        busy_d = (state_d != DIV_IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= CNT_ZERO;
            divisor_q <= {XLEN{1'b0}};
            quo_q     <= {XLEN{1'b0}};
            rem_acc_q <= {(XLEN+1){1'b0}};
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            quo_out_q <= {XLEN{1'b0}};
            rem_out_q <= {XLEN{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            rem_acc_q <= rem_acc_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
        end
    end

    assign bus.done_o = done_q;
    assign bus.busy_o = busy_q;
    assign bus.quo_o  = quo_out_q;
    assign bus.rem_o  = rem_out_q;

endmodule

// File: tb/tb_div_iter_core.sv
// Scoreboard bench for div_iter_core: directed scenarios plus random pairs
// checked for quotient, remainder and exact done latency.
module tb_div_iter_core;
    import div_iter_core_pkg::*;

    typedef struct {
        logic [XLEN-1:0] quo;
        logic [XLEN-1:0] rem;
        int              lat;
    } exp_t;

    exp_t sb_q[$];
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    always #5 clk = ~clk;

    div_iter_core_if bus ();

    div_iter_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the golden result, present operands with a one-cycle start pulse
    task automatic start_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.quo = 32'hFFFF_FFFF; e.rem = a; e.lat = 1;
        end else begin
            e.quo = a / b; e.rem = a % b; e.lat = XLEN + 1;
        end
        sb_q.push_back(e);
        bus.opr1_i  = a;
        bus.opr2_i  = b;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.opr1_i  = $urandom;
        bus.opr2_i  = $urandom;
    endtask

    // Wait (bounded) for done; optionally inject a stray 9/3 start at cycle stray_at
    task automatic wait_done(input int stray_at, output int lat);
        lat = 0;
        while (bus.done_o !== 1'b1 && lat < 100) begin
            if (lat == stray_at) begin
                bus.opr1_i  = 32'd9;
                bus.opr2_i  = 32'd3;
                bus.start_i = 1'b1;
            end
            tick();
            bus.start_i = 1'b0;
            lat++;
        end
        if (bus.done_o !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        bus.start_i = 1'b0;
        bus.opr1_i  = 32'd0;
        bus.opr2_i  = 32'd0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_cnt++; if (bus.done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done_o); else pass_cnt++;
        chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_o); else pass_cnt++;
        chk_cnt++; if (bus.quo_o !== 32'd0) $display("FAIL reset_quo: got %h want 0", bus.quo_o); else pass_cnt++;
        chk_cnt++; if (bus.rem_o !== 32'd0) $display("FAIL reset_rem: got %h want 0", bus.rem_o); else pass_cnt++;
    endtask

    task automatic test_basic();
        exp_t e;
        int   lat;
        start_op(32'd100, 32'd7);
        chk_cnt++; if (bus.busy_o !== 1'b1) $display("FAIL basic_busy: got %b want 1", bus.busy_o); else pass_cnt++;
        wait_done(-1, lat);
        e = sb_q.pop_front();
        chk_cnt++; if (lat !== e.lat) $display("FAIL basic_lat: got %0d want %0d", lat, e.lat); else pass_cnt++;
        chk_cnt++; if (bus.quo_o !== e.quo) $display("FAIL basic_quo: got %0d want %0d", bus.quo_o, e.quo); else pass_cnt++;
        chk_cnt++; if (bus.rem_o !== e.rem) $display("FAIL basic_rem: got %0d want %0d", bus.rem_o, e.rem); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.done_o !== 1'b0) $display("FAIL basic_done_width: got %b want 0", bus.done_o); else pass_cnt++;
        chk_cnt++; if (bus.quo_o !== 32'd14) $display("FAIL basic_quo_hold: got %0d want 14", bus.quo_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        start_op(32'hFFFF_FFFF, 32'd1);
        wait_done(-1, lat);
        e = sb_q.pop_front();
        chk_cnt++; if (bus.quo_o !== e.quo) $display("FAIL b2b_first_quo: got %h want %h", bus.quo_o, e.quo); else pass_cnt++;
        chk_cnt++; if (bus.rem_o !== e.rem) $display("FAIL b2b_first_rem: got %h want %h", bus.rem_o, e.rem); else pass_cnt++;
        start_op(32'd5, 32'd9);
        wait_done(-1, lat);
        e = sb_q.pop_front();
        chk_cnt++; if (lat !== e.lat) $display("FAIL b2b_lat: got %0d want %0d", lat, e.lat); else pass_cnt++;
        chk_cnt++; if (bus.quo_o !== e.quo) $display("FAIL b2b_quo: got %0d want %0d", bus.quo_o, e.quo); else pass_cnt++;
        chk_cnt++; if (bus.rem_o !== e.rem) $display("FAIL b2b_rem: got %0d want %0d", bus.rem_o, e.rem); else pass_cnt++;
        tick();
    endtask

    task automatic test_div_zero();
        exp_t e;
        int   lat;
        start_op(32'h0000_1234, 32'd0);
        wait_done(-1, lat);
        e = sb_q.pop_front();
        chk_cnt++; if (lat !== e.lat) $display("FAIL div0_lat: got %0d want %0d", lat, e.lat); else pass_cnt++;
        chk_cnt++; if (bus.quo_o !== e.quo) $display("FAIL div0_quo: got %h want %h", bus.quo_o, e.quo); else pass_cnt++;
        chk_cnt++; if (bus.rem_o !== e.rem) $display("FAIL div0_rem: got %h want %h", bus.rem_o, e.rem); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.done_o !== 1'b0) $display("FAIL div0_done_width: got %b want 0", bus.done_o); else pass_cnt++;
    endtask

    task automatic test_boundary();
        exp_t e;
        int   lat;
        start_op(32'h8000_0000, 32'h8000_0000);
        wait_done(-1, lat);
        e = sb_q.pop_front();
        chk_cnt++; if (bus.quo_o !== e.quo) $display("FAIL bnd_msb_quo: got %h want %h", bus.quo_o, e.quo); else pass_cnt++;
        chk_cnt++; if (bus.rem_o !== e.rem) $display("FAIL bnd_msb_rem: got %h want %h", bus.rem_o, e.rem); else pass_cnt++;
        tick();
        start_op(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        wait_done(-1, lat);
        e = sb_q.pop_front();
        chk_cnt++; if (bus.quo_o !== e.quo) $display("FAIL bnd_big_quo: got %h want %h", bus.quo_o, e.quo); else pass_cnt++;
        chk_cnt++; if (bus.rem_o !== e.rem) $display("FAIL bnd_big_rem: got %h want %h", bus.rem_o, e.rem); else pass_cnt++;
        tick();
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   lat;
        int   extra;
        start_op(32'd100, 32'd7);
        wait_done(10, lat);
        e = sb_q.pop_front();
        chk_cnt++; if (lat !== e.lat) $display("FAIL ign_lat: got %0d want %0d", lat, e.lat); else pass_cnt++;
        chk_cnt++; if (bus.quo_o !== e.quo) $display("FAIL ign_quo: got %0d want %0d", bus.quo_o, e.quo); else pass_cnt++;
        chk_cnt++; if (bus.rem_o !== e.rem) $display("FAIL ign_rem: got %0d want %0d", bus.rem_o, e.rem); else pass_cnt++;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done_o === 1'b1) extra++;
        end
        chk_cnt++; if (extra !== 0) $display("FAIL ign_extra_done: got %0d pulses want 0", extra); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        int   extra;
        bus.opr1_i  = 32'd100;
        bus.opr2_i  = 32'd7;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (14) tick();
        chk_cnt++; if (bus.busy_o !== 1'b1) $display("FAIL rstmid_busy_pre: got %b want 1", bus.busy_o); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy_o); else pass_cnt++;
        chk_cnt++; if (bus.quo_o !== 32'd0) $display("FAIL rstmid_quo: got %h want 0", bus.quo_o); else pass_cnt++;
        chk_cnt++; if (bus.rem_o !== 32'd0) $display("FAIL rstmid_rem: got %h want 0", bus.rem_o); else pass_cnt++;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o === 1'b1) extra++;
            tick();
        end
        chk_cnt++; if (extra !== 0) $display("FAIL rstmid_done: got %0d pulses want 0", extra); else pass_cnt++;
        start_op(32'd50, 32'd5);
        wait_done(-1, lat);
        e = sb_q.pop_front();
        chk_cnt++; if (lat !== e.lat) $display("FAIL rstmid_lat: got %0d want %0d", lat, e.lat); else pass_cnt++;
        chk_cnt++; if (bus.quo_o !== e.quo) $display("FAIL rstmid_quo2: got %0d want %0d", bus.quo_o, e.quo); else pass_cnt++;
        chk_cnt++; if (bus.rem_o !== e.rem) $display("FAIL rstmid_rem2: got %0d want %0d", bus.rem_o, e.rem); else pass_cnt++;
        tick();
    endtask

    task automatic test_random();
        exp_t            e;
        int              lat;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = a;
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            start_op(a, b);
            wait_done(-1, lat);
            e = sb_q.pop_front();
            chk_cnt++; if (lat !== e.lat) $display("FAIL rnd_lat %h/%h: got %0d want %0d", a, b, lat, e.lat); else pass_cnt++;
            chk_cnt++; if (bus.quo_o !== e.quo) $display("FAIL rnd_quo %h/%h: got %h want %h", a, b, bus.quo_o, e.quo); else pass_cnt++;
            chk_cnt++; if (bus.rem_o !== e.rem) $display("FAIL rnd_rem %h/%h: got %h want %h", a, b, bus.rem_o, e.rem); else pass_cnt++;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_boundary();
        test_start_ignored();
        test_reset_mid();
        test_random();
        chk_cnt++; if (sb_q.size() !== 0) $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
